// File: rtl/control_sequencer.sv
// Microcoded control sequencer for a bus-based 8-bit CPU.
// Five-step instruction cycle (T0..T4) with fetch, decode and halt handling.
module control_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output logic       program_counter_bus_enable_n,
  output logic       program_counter_enable,
  output logic       jump_n,
  output logic       ram_load_mar_reg_n,
  output logic       ram_bus_enable_n,
  output logic       ram_write_enable_n,
  output logic       ir_load_n,
  output logic       ir_bus_enable_n,
  output logic       reg_a_load_n,
  output logic       reg_a_bus_enable_n,
  output logic       reg_b_load_n,
  output logic       alu_enable_n,
  output logic       alu_subtract,
  output logic       flags_load_n,
  output logic       out_load_n,
  output logic       halt,
  output logic [2:0] step
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic [1:0] state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [2:0] last_step;

  always_comb begin
    case (opcode)
      OP_LDA, OP_STA: last_step = 3'd3;
      OP_ADD, OP_SUB: last_step = 3'd4;
      default:        last_step = 3'd2;
    endcase
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: begin
        step_d = 3'd0;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        // Steps 0/1 are below every last_step, so the decode only matters from T2.
        if (step_q >= last_step) begin
          step_d = 3'd0;
          if (opcode == OP_HLT) state_d = S_HALT;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      S_HALT: step_d = 3'd0;
      default: begin
        state_d = S_IDLE;
        step_d  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    program_counter_bus_enable_n = 1'b1;
    program_counter_enable       = 1'b0;
    jump_n                       = 1'b1;
    ram_load_mar_reg_n           = 1'b1;
    ram_bus_enable_n             = 1'b1;
    ram_write_enable_n           = 1'b1;
    ir_load_n                    = 1'b1;
    ir_bus_enable_n              = 1'b1;
    reg_a_load_n                 = 1'b1;
    reg_a_bus_enable_n           = 1'b1;
    reg_b_load_n                 = 1'b1;
    alu_enable_n                 = 1'b1;
    alu_subtract                 = 1'b0;
    flags_load_n                 = 1'b1;
    out_load_n                   = 1'b1;
    if (state_q == S_RUN) begin
      case (step_q)
        3'd0: begin
          program_counter_bus_enable_n = 1'b0;
          ram_load_mar_reg_n           = 1'b0;
        end
        3'd1: begin
          ram_bus_enable_n       = 1'b0;
          ir_load_n              = 1'b0;
          program_counter_enable = 1'b1;
        end
        3'd2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_bus_enable_n    = 1'b0;
              ram_load_mar_reg_n = 1'b0;
            end
            OP_LDI: begin
              ir_bus_enable_n = 1'b0;
              reg_a_load_n    = 1'b0;
            end
            OP_JMP: begin
              ir_bus_enable_n = 1'b0;
              jump_n          = 1'b0;
            end
            OP_JC: begin
              ir_bus_enable_n = 1'b0;
              jump_n          = ~carry_flag;
            end
            OP_JZ: begin
              ir_bus_enable_n = 1'b0;
              jump_n          = ~zero_flag;
            end
            OP_OUT: begin
              reg_a_bus_enable_n = 1'b0;
              out_load_n         = 1'b0;
            end
            default: ;
          endcase
        end
        3'd3: begin
          case (opcode)
            OP_LDA: begin
              ram_bus_enable_n = 1'b0;
              reg_a_load_n     = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              ram_bus_enable_n = 1'b0;
              reg_b_load_n     = 1'b0;
              alu_subtract     = (opcode == OP_SUB);
            end
            OP_STA: begin
              reg_a_bus_enable_n = 1'b0;
              ram_write_enable_n = 1'b0;
            end
            default: ;
          endcase
        end
        3'd4: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_enable_n = 1'b0;
            reg_a_load_n = 1'b0;
            flags_load_n = 1'b0;
            alu_subtract = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign halt = (state_q == S_HALT);
  assign step = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized and directed check of control_sequencer against a
// microcode-table reference model.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, carry_flag, zero_flag;
  logic [3:0] opcode;
  logic       pc_oe_n, pc_en, jump_n, mar_n, ram_oe_n, ram_we_n;
  logic       ir_ld_n, ir_oe_n, a_ld_n, a_oe_n, b_ld_n, alu_oe_n;
  logic       alu_sub, flg_ld_n, out_ld_n, halt;
  logic [2:0] step;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk                          (clk),
    .reset                        (reset),
    .start                        (start),
    .opcode                       (opcode),
    .carry_flag                   (carry_flag),
    .zero_flag                    (zero_flag),
    .program_counter_bus_enable_n (pc_oe_n),
    .program_counter_enable       (pc_en),
    .jump_n                       (jump_n),
    .ram_load_mar_reg_n           (mar_n),
    .ram_bus_enable_n             (ram_oe_n),
    .ram_write_enable_n           (ram_we_n),
    .ir_load_n                    (ir_ld_n),
    .ir_bus_enable_n              (ir_oe_n),
    .reg_a_load_n                 (a_ld_n),
    .reg_a_bus_enable_n           (a_oe_n),
    .reg_b_load_n                 (b_ld_n),
    .alu_enable_n                 (alu_oe_n),
    .alu_subtract                 (alu_sub),
    .flags_load_n                 (flg_ld_n),
    .out_load_n                   (out_ld_n),
    .halt                         (halt),
    .step                         (step)
  );

  // One bit per control, 1 = asserted regardless of pin polarity.
  localparam logic [14:0] PCO = 15'h0001;
  localparam logic [14:0] PCE = 15'h0002;
  localparam logic [14:0] JMP = 15'h0004;
  localparam logic [14:0] MAR = 15'h0008;
  localparam logic [14:0] RMO = 15'h0010;
  localparam logic [14:0] RMW = 15'h0020;
  localparam logic [14:0] IRL = 15'h0040;
  localparam logic [14:0] IRO = 15'h0080;
  localparam logic [14:0] AL  = 15'h0100;
  localparam logic [14:0] AO  = 15'h0200;
  localparam logic [14:0] BL  = 15'h0400;
  localparam logic [14:0] ALU = 15'h0800;
  localparam logic [14:0] SUB = 15'h1000;
  localparam logic [14:0] FL  = 15'h2000;
  localparam logic [14:0] OL  = 15'h4000;
  localparam logic [14:0] BUS = PCO | RMO | IRO | AO | ALU;

  int n_tests = 0;
  int n_fail  = 0;

  logic [14:0] ucode [16][5];
  int          ulen  [16];
  int          ucond [16];

  int m_state;
  int m_step;
  int cur_op;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] observed();
    return {~out_ld_n, ~flg_ld_n, alu_sub, ~alu_oe_n, ~b_ld_n, ~a_oe_n,
            ~a_ld_n, ~ir_oe_n, ~ir_ld_n, ~ram_we_n, ~ram_oe_n, ~mar_n,
            ~jump_n, pc_en, ~pc_oe_n};
  endfunction

  function automatic logic [14:0] expected(bit c, bit z);
    logic [14:0] w;
    if (m_state != 1) return 15'h0;
    if (m_step == 0) return PCO | MAR;
    if (m_step == 1) return RMO | IRL | PCE;
    w = ucode[cur_op][m_step];
    if (m_step == 2 && ucond[cur_op] == 1 && c) w |= JMP;
    if (m_step == 2 && ucond[cur_op] == 2 && z) w |= JMP;
    return w;
  endfunction

  function automatic int popc(logic [14:0] v);
    int n = 0;
    for (int i = 0; i < 15; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic cycle(bit st, bit rst, int next_op, bit c, bit z);
    logic [14:0] ob;
    @(negedge clk);
    if (!(m_state == 1 && m_step >= 2)) cur_op = next_op;
    start      = st;
    reset      = rst;
    carry_flag = c;
    zero_flag  = z;
    opcode     = (m_state == 1 && m_step >= 2) ? 4'(cur_op)
                                               : 4'($urandom_range(0, 15));
    if (rst) begin
      m_state = 0;
      m_step  = 0;
    end
    #1;
    ob = observed();
    check("ctrl", 32'(ob), 32'(expected(c, z)));
    check("step", 32'(step), 32'(m_step));
    check("halt", 32'(halt), 32'(m_state == 2));
    check("bus1", 32'(popc(ob & BUS) <= 1), 32'd1);
    check("steprange", 32'(step <= 3'd4), 32'd1);
    @(posedge clk);
    if (!rst) begin
      if (m_state == 0 && st) begin
        m_state = 1;
        m_step  = 0;
      end else if (m_state == 1) begin
        if (m_step == ulen[cur_op] - 1) begin
          if (cur_op == 15) m_state = 2;
          m_step = 0;
        end else begin
          m_step++;
        end
      end
    end
  endtask

  task automatic run_instr(int op, bit c, bit z);
    for (int i = 0; i < ulen[op]; i++) cycle(1'b0, 1'b0, op, c, z);
  endtask

  initial begin
    for (int o = 0; o < 16; o++) begin
      ulen[o]  = 3;
      ucond[o] = 0;
      for (int k = 0; k < 5; k++) ucode[o][k] = 15'h0;
    end
    ulen[1] = 4; ucode[1][2] = IRO | MAR; ucode[1][3] = RMO | AL;
    ulen[2] = 5; ucode[2][2] = IRO | MAR; ucode[2][3] = RMO | BL;
    ucode[2][4] = ALU | AL | FL;
    ulen[3] = 5; ucode[3][2] = IRO | MAR; ucode[3][3] = RMO | BL | SUB;
    ucode[3][4] = ALU | AL | FL | SUB;
    ulen[4] = 4; ucode[4][2] = IRO | MAR; ucode[4][3] = AO | RMW;
    ucode[5][2] = IRO | AL;
    ucode[6][2] = IRO | JMP;
    ucode[7][2] = IRO; ucond[7] = 1;
    ucode[8][2] = IRO; ucond[8] = 2;
    ucode[14][2] = AO | OL;

    m_state = 0; m_step = 0; cur_op = 0;
    reset = 1'b1; start = 1'b0; opcode = 4'h0;
    carry_flag = 1'b0; zero_flag = 1'b0;

    // reset state, then idle with start=1 under reset
    cycle(1'b1, 1'b1, 0, 0, 0);
    cycle(1'b0, 1'b0, 0, 0, 0);
    cycle(1'b0, 1'b0, 0, 0, 0);

    // directed program covering every opcode class
    cycle(1'b1, 1'b0, 1, 0, 0);
    run_instr(1, 1, 1);
    run_instr(2, 0, 1);
    run_instr(3, 1, 0);
    run_instr(4, 0, 0);
    run_instr(5, 1, 1);
    run_instr(6, 0, 0);
    run_instr(7, 0, 1);
    run_instr(7, 1, 0);
    run_instr(8, 1, 0);
    run_instr(8, 0, 1);
    run_instr(14, 0, 0);
    run_instr(0, 1, 1);
    run_instr(10, 0, 0);
    run_instr(15, 0, 0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1, i[0], i[1]);
    cycle(1'b0, 1'b1, 0, 0, 0);
    cycle(1'b0, 1'b0, 0, 0, 0);

    // reset asynchronously in the middle of ADD T3
    cycle(1'b1, 1'b0, 2, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2, 0, 0);
    cycle(1'b1, 1'b1, 2, 1, 1);
    cycle(1'b0, 1'b0, 1, 0, 0);
    cycle(1'b1, 1'b0, 1, 0, 0);
    run_instr(1, 0, 0);

    // random opcode stream with random flags, start and resets
    for (int i = 0; i < 4000; i++) begin
      int op;
      bit rst;
      op = $urandom_range(0, 15);
      if (op == 15 && $urandom_range(0, 3) != 0) op = $urandom_range(0, 14);
      rst = ($urandom_range(0, 299) == 0) ||
            (m_state == 2 && $urandom_range(0, 9) == 0);
      cycle(1'($urandom_range(0, 1)), rst, op,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
